buzzer_tone_generator: RTL and testbench

Converts the 6-bit note index produced by `buzzer_controller` into a square wave that drives the board's passive buzzer pin. It sits directly downstream of `buzzer_controller` and upstream of the top-level buzzer output. It holds the current pitch glitch-free and switches pitch only at half-period boundaries. Note 0, and any note index outside the table, is silence.

---
 rtl/buzzer_pkg.sv | 30 +++
 rtl/buzzer_tone_generator_rom.sv | 31 +++
 rtl/buzzer_tone_generator.sv | 98 +++++++++
 tb/tb_buzzer_tone_generator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared note encoding and equal-tempered pitch table for the buzzer path.
// Pure constants and a helper; no logic, no latency, no backpressure.
package buzzer_pkg;

   localparam int                NOTE_W      = 6;
   localparam logic [NOTE_W-1:0] NOTE_SILENT = 6'd0;
   localparam logic [NOTE_W-1:0] NOTE_MAX    = 6'd48;

   localparam logic [NOTE_W-1:0] NOTE_C3 = 6'd1;
   localparam logic [NOTE_W-1:0] NOTE_A3 = 6'd10;
   localparam logic [NOTE_W-1:0] NOTE_A4 = 6'd22;
   localparam logic [NOTE_W-1:0] NOTE_A5 = 6'd34;

   // Chromatic C3..B6 in centi-Hz, A4 = 440.00 Hz.
   localparam int unsigned F_CENTI [1:48] = '{
       13081,  13859,  14683,  15556,  16481,  17461,
       18500,  19600,  20765,  22000,  23308,  24694,
       26163,  27718,  29366,  31113,  32963,  34923,
       36999,  39200,  41530,  44000,  46616,  49388,
       52325,  55437,  58733,  62225,  65926,  69846,
       73999,  78399,  83061,  88000,  93233,  98777,
      104650, 110873, 117466, 124451, 131851, 139691,
      147998, 156798, 166122, 176000, 186466, 197553
   };

   function automatic logic note_is_tone(input logic [NOTE_W-1:0] n);
      return (n != NOTE_SILENT) && (n <= NOTE_MAX);
   endfunction

endpackage

// File: rtl/buzzer_tone_generator_rom.sv
// Note index to half-period clock count; combinational, zero latency, no backpressure.
// Silent or out-of-table indices return 0.
module note_period_rom
   import buzzer_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned CNT_W  = 20
) (
   input  logic [NOTE_W-1:0] note_i,
   output logic [CNT_W-1:0]  half_o
);

   logic [CNT_W-1:0] tbl [0:(1<<NOTE_W)-1];

   genvar i;
   generate
      for (i = 0; i < (1 << NOTE_W); i++) begin : g_tbl
         if (i >= 1 && i <= int'(NOTE_MAX)) begin : g_note
            // 64-bit so CLK_HZ*50 cannot overflow at elaboration.
            localparam longint unsigned RAW     = (64'(CLK_HZ) * 64'd50) / 64'(F_CENTI[i]);
            localparam longint unsigned CLAMPED = (RAW < 64'd2) ? 64'd2 : RAW;
            assign tbl[i] = CLAMPED[CNT_W-1:0];
         end else begin : g_silent
            assign tbl[i] = '0;
         end
      end
   endgenerate

   assign half_o = tbl[note_i];

endmodule

// File: rtl/buzzer_tone_generator.sv
// Square-wave buzzer drive from a note index; 2-edge note-to-output latency.
// No backpressure: the note input is sampled every cycle.
module buzzer_tone_generator
   import buzzer_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned CNT_W  = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NOTE_W-1:0] note,
   output logic              buzzer,
   output logic              tone_active
);

   localparam logic [0:0] ST_SILENT = 1'b0;
   localparam logic [0:0] ST_TONE   = 1'b1;

   logic [NOTE_W-1:0] note_q;
   logic [0:0]        state_q,  state_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              buzzer_q, buzzer_d;
   logic              tone_q,   tone_d;
   logic [CNT_W-1:0]  half;
   logic              note_ok;

   note_period_rom #(
      .CLK_HZ (CLK_HZ),
      .CNT_W  (CNT_W)
   ) u_rom (
      .note_i (note_q),
      .half_o (half)
   );

   assign note_ok = note_is_tone(note_q);

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      buzzer_d = buzzer_q;
      tone_d   = tone_q;
      case (state_q)
         ST_SILENT: begin
            buzzer_d = 1'b0;
            tone_d   = 1'b0;
            cnt_d    = '0;
            if (note_ok) begin
               period_d = half;
               buzzer_d = 1'b1;
               tone_d   = 1'b1;
               state_d  = ST_TONE;
            end
         end
         ST_TONE: begin
            if (!note_ok) begin
               buzzer_d = 1'b0;
               tone_d   = 1'b0;
               cnt_d    = '0;
               state_d  = ST_SILENT;
            end else if (cnt_q == period_q - CNT_W'(1)) begin
               // Pitch is only picked up here so no half-period is ever cut short.
               buzzer_d = ~buzzer_q;
               cnt_d    = '0;
               period_d = half;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_SILENT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         note_q   <= NOTE_SILENT;
         state_q  <= ST_SILENT;
         period_q <= '0;
         cnt_q    <= '0;
         buzzer_q <= 1'b0;
         tone_q   <= 1'b0;
      end else begin
         note_q   <= note;
         state_q  <= state_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         buzzer_q <= buzzer_d;
         tone_q   <= tone_d;
      end
   end

   assign buzzer      = buzzer_q;
   assign tone_active = tone_q;

endmodule

// File: tb/tb_buzzer_tone_generator.sv
// Directed bench for buzzer_tone_generator at CLK_HZ = 1 MHz.
// Inputs change and outputs are sampled on the falling edge.
module tb_buzzer_tone_generator;

   localparam int H22 = 1136;
   localparam int H34 = 568;
   localparam int H10 = 2272;
   localparam int BUDGET = 5000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] note = 6'd0;
   logic       buzzer;
   logic       tone_active;

   int n_cmp = 0;
   int n_bad = 0;

   buzzer_tone_generator #(
      .CLK_HZ (1_000_000),
      .CNT_W  (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .note        (note),
      .buzzer      (buzzer),
      .tone_active (tone_active)
   );

   always #5 clk = ~clk;

   // Counts consecutive samples at level lvl, including the one already seen.
   task automatic measure(input logic lvl, output int len);
      len = 1;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if (buzzer !== lvl) break;
         len++;
      end
   endtask

   task automatic go_silent();
      note = 6'd0;
      repeat (4) @(negedge clk);
   endtask

   // Drives a note from silence and checks the 2-edge rise.
   task automatic start_note(input logic [5:0] n, input string tag);
      note = n;
      @(negedge clk);
      n_cmp++;
      if (buzzer !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_latency1: buzzer=%b required 0", tag, buzzer);
      end
      @(negedge clk);
      n_cmp++;
      if (buzzer !== 1'b1 || tone_active !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_rise: buzzer=%b tone_active=%b required 1/1", tag, buzzer, tone_active);
      end
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1;
      note  = 6'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (buzzer !== 1'b0 || tone_active !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold[%0d]: buzzer=%b tone_active=%b required 0/0", i, buzzer, tone_active);
         end
      end
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (buzzer !== 1'b0 || tone_active !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL reset_idle: %0d active cycles required 0", bad);
      end
   endtask

   task automatic test_steady_a4();
      int len;
      logic lvl;
      start_note(6'd22, "steady");
      lvl = 1'b1;
      for (int p = 0; p < 20; p++) begin
         measure(lvl, len);
         n_cmp++;
         if (len != H22) begin
            n_bad++;
            $display("FAIL steady_phase[%0d]: length %0d required %0d", p, len, H22);
         end
         lvl = ~lvl;
      end
      go_silent();
   endtask

   task automatic test_pitch_change();
      int len;
      logic lvl;
      start_note(6'd22, "pitch");
      len = 1;
      for (int i = 0; i < BUDGET; i++) begin
         if (len == 501) note = 6'd34;
         @(negedge clk);
         if (buzzer !== 1'b1) break;
         len++;
      end
      n_cmp++;
      if (len != H22) begin
         n_bad++;
         $display("FAIL pitch_old_phase: length %0d required %0d", len, H22);
      end
      lvl = 1'b0;
      for (int p = 0; p < 6; p++) begin
         measure(lvl, len);
         n_cmp++;
         if (len != H34) begin
            n_bad++;
            $display("FAIL pitch_new_phase[%0d]: length %0d required %0d", p, len, H34);
         end
         lvl = ~lvl;
      end
      go_silent();
   endtask

   // Starts note 22, then switches to stop_n at cnt = 300 of the first high phase.
   task automatic silence_mid(input logic [5:0] stop_n, input string tag);
      int bad;
      start_note(6'd22, tag);
      repeat (300) @(negedge clk);
      note = stop_n;
      @(negedge clk);
      n_cmp++;
      if (buzzer !== 1'b1 || tone_active !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_edge1: buzzer=%b tone_active=%b required 1/1", tag, buzzer, tone_active);
      end
      @(negedge clk);
      n_cmp++;
      if (buzzer !== 1'b0 || tone_active !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_edge2: buzzer=%b tone_active=%b required 0/0", tag, buzzer, tone_active);
      end
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (buzzer !== 1'b0 || tone_active !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL %s_stays_off: %0d active cycles required 0", tag, bad);
      end
      go_silent();
   endtask

   task automatic test_silence_mid();
      silence_mid(6'd0, "silence");
   endtask

   task automatic test_invalid_note();
      int bad;
      note = 6'd50;
      bad = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (buzzer !== 1'b0 || tone_active !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL invalid50_idle: %0d active cycles required 0", bad);
      end
      go_silent();
      silence_mid(6'd63, "invalid63");
   endtask

   task automatic test_reset_mid_tone();
      int len;
      start_note(6'd10, "rstmid");
      repeat (1000) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (buzzer !== 1'b0 || tone_active !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_clear: buzzer=%b tone_active=%b required 0/0", buzzer, tone_active);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (buzzer !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_relatency1: buzzer=%b required 0", buzzer);
      end
      @(negedge clk);
      n_cmp++;
      if (buzzer !== 1'b1 || tone_active !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_rerise: buzzer=%b tone_active=%b required 1/1", buzzer, tone_active);
      end
      measure(1'b1, len);
      n_cmp++;
      if (len != H10) begin
         n_bad++;
         $display("FAIL rstmid_high: length %0d required %0d", len, H10);
      end
      measure(1'b0, len);
      n_cmp++;
      if (len != H10) begin
         n_bad++;
         $display("FAIL rstmid_low: length %0d required %0d", len, H10);
      end
      go_silent();
   endtask

   initial begin
      test_reset();
      test_steady_a4();
      test_pitch_change();
      test_silence_mid();
      test_invalid_note();
      test_reset_mid_tone();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
